// File: rtl/multicomp_serial_pkg.sv
// rtl/multicomp_serial_pkg.sv - shared serial definitions for the MultiComp UART blocks
// Contents: rx deframer state enum, oversample ratio, 50 MHz baud increments.
package multicomp_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Phase increments for a 16-bit accumulator clocked at 50 MHz (16x oversample).
  localparam logic [15:0] BAUD_INC_115200 = 16'd2416;
  localparam logic [15:0] BAUD_INC_38400  = 16'd805;
  localparam logic [15:0] BAUD_INC_19200  = 16'd403;
  localparam logic [15:0] BAUD_INC_9600   = 16'd201;
  localparam logic [15:0] BAUD_INC_4800   = 16'd101;
  localparam logic [15:0] BAUD_INC_2400   = 16'd50;

endpackage

// File: rtl/serial_fifo.sv
// rtl/serial_fifo.sv - synchronous first-word-fall-through FIFO
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     write strobe and data (accepted when not full, or full with a pop)
//   pop                 read strobe (ignored when empty)
//   head_data           current head, 0 when empty
//   count, full, empty  occupancy status
module serial_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  // Empty FIFO presents zero rather than stale storage.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 serial receiver with FIFO, sticky errors and RTS hysteresis
// Ports:
//   clk, reset       50 MHz system clock, asynchronous active-high reset
//   baud_increment   phase increment; accumulator carry is the 16x oversample tick
//   rxd              asynchronous serial input, idle high
//   rd               single-cycle pop strobe
//   rx_data          FIFO head (first-word fall-through)
//   rx_valid         FIFO non-empty
//   fifo_count       occupancy
//   rts              0 = sender may transmit
//   framing_err      sticky, stop bit sampled low
//   overrun_err      sticky, byte arrived with FIFO full and no pop
//   clr_err          clears both sticky flags (a same-cycle set wins)
module uart_rx_fifo
  import multicomp_serial_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_HIGH   = 12,
  parameter int RTS_LOW    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [15:0]                     baud_increment,
  input  logic                            rxd,
  input  logic                            rd,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            rts,
  output logic                            framing_err,
  output logic                            overrun_err,
  input  logic                            clr_err
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]    RTS_HIGH_C = CW'(RTS_HIGH);
  localparam logic [CW-1:0]    RTS_LOW_C  = CW'(RTS_LOW);

  // Oversample tick: carry out of the phase accumulator.
  logic [15:0] acc;
  logic [16:0] acc_sum;
  logic        tick;

  assign acc_sum = {1'b0, acc} + {1'b0, baud_increment};
  assign tick    = acc_sum[16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else       acc <= acc_sum[15:0];
  end

  // Two-flop synchroniser, idle-high reset so no false start edge after reset.
  logic rxd_meta;
  logic rxd_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Deframer FSM.
  rx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shreg, shreg_d;
  logic             push;
  logic             frame_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          // Re-check at mid start bit; a short low pulse is rejected here.
          if (cnt == CNT_MID) begin
            cnt_d = '0;
            if (!rxd_s) begin
              state_d   = DATA;
              bit_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_d   = '0;
            shreg_d = {rxd_s, shreg[7:1]};
            if (bit_idx == 3'd7) state_d = STOP;
            else                 bit_idx_d = bit_idx + 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_d = '0;
            if (rxd_s) begin
              push    = 1'b1;
              state_d = IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = BREAK;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxd_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO.
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] count;

  serial_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (rd),
    .head_data (rx_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid   = !fifo_empty;
  assign fifo_count = count;

  // A byte is lost only if the FIFO is full and no pop frees a slot this cycle.
  logic overrun_set;
  assign overrun_set = push && fifo_full && !(rd && !fifo_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      rts         <= 1'b0;
    end else begin
      if (frame_set)    framing_err <= 1'b1;
      else if (clr_err) framing_err <= 1'b0;

      if (overrun_set)  overrun_err <= 1'b1;
      else if (clr_err) overrun_err <= 1'b0;

      if (count >= RTS_HIGH_C)     rts <= 1'b1;
      else if (count <= RTS_LOW_C) rts <= 1'b0;
    end
  end

endmodule
